// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- constants shared by the fetch stage and its instruction memory.
//   INSTR_W            : instruction word width in bits
//   NOP_INSTR          : bubble inserted into IF/ID when nothing valid is fetched
//   DEFAULT_IMEM_DEPTH : default instruction memory depth in words
// ---------------------------------------------------------------------------
package cpu_pkg;
    localparam int INSTR_W            = 32;
    localparam int DEFAULT_IMEM_DEPTH = 64;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem -- instruction word storage, one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk    in   clock; writes commit on the rising edge
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address
//   rdata  out  read data, combinational from raddr
// ---------------------------------------------------------------------------
module instr_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  instr_t        wdata,
    input  logic [AW-1:0] raddr,
    output instr_t        rdata
);

    instr_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage -- program loader plus PC / IF/ID register of a simple
// in-order pipeline.
// Ports:
//   clk              in   clock
//   Reset            in   synchronous active-high reset (PC, IF/ID, load pointer)
//   LoadInstructions in   load mode: Instruction is written at the load pointer
//   Instruction      in   word to load
//   stall            in   hold PC and IF/ID
//   branch_taken     in   redirect PC to branch_target and flush IF/ID
//   branch_target    in   redirect byte address (low two bits ignored)
//   if_id_instr      out  registered instruction for decode
//   if_id_pc_plus4   out  registered PC+4 of that instruction
//   if_id_valid      out  if_id_instr is a real fetched instruction
//   prog_len         out  number of words loaded
//   imem_full        out  load pointer has reached IMEM_DEPTH
//   fetch_count      out  saturating count of valid fetches    (IF_PERF_COUNT_EN)
//   stall_count      out  saturating count of stall cycles     (IF_PERF_COUNT_EN)
// Build option: define IF_PERF_COUNT_EN to add the two performance counters.
// ---------------------------------------------------------------------------
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       LoadInstructions,
    input  logic [INSTR_W-1:0]         Instruction,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    output logic [INSTR_W-1:0]         if_id_instr,
    output logic [31:0]                if_id_pc_plus4,
    output logic                       if_id_valid,
    output logic [$clog2(IMEM_DEPTH):0] prog_len,
`ifdef IF_PERF_COUNT_EN
    output logic [31:0]                fetch_count,
    output logic [31:0]                stall_count,
`endif
    output logic                       imem_full
);

    localparam int          AW        = $clog2(IMEM_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = IMEM_DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE   = 1;

    logic [31:0]  pc_q, pc_d;
    instr_t       if_id_instr_q, if_id_instr_d;
    logic [31:0]  if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [AW:0]  ld_ptr_q, ld_ptr_d;
    // prog_len and imem_full are outside Reset so a loaded program survives it;
    // they still need a defined power-up value.
    logic [AW:0]  prog_len_q = '0;
    logic [AW:0]  prog_len_d;
    logic         imem_full_q = 1'b0;
    logic         imem_full_d;

    logic         mem_we;
    instr_t       mem_rdata;
    logic         fetch_ok;
    logic         fetch_fire;

    instr_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_ptr_q[AW-1:0]),
        .wdata (Instruction),
        .raddr (pc_q[AW+1:2]),
        .rdata (mem_rdata)
    );

    // Word index compared at full width: a PC far beyond the memory must halt,
    // not alias back into it.
    assign fetch_ok = ({2'b00, pc_q[31:2]} < {{(31-AW){1'b0}}, prog_len_q});

    always_comb begin
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        ld_ptr_d         = ld_ptr_q;
        prog_len_d       = prog_len_q;
        imem_full_d      = imem_full_q;
        mem_we           = 1'b0;
        fetch_fire       = 1'b0;

        if (Reset) begin
            pc_d             = '0;
            if_id_instr_d    = NOP_INSTR;
            if_id_pc_plus4_d = '0;
            if_id_valid_d    = 1'b0;
            ld_ptr_d         = '0;
        end else if (LoadInstructions) begin
            pc_d             = '0;
            if_id_instr_d    = NOP_INSTR;
            if_id_pc_plus4_d = '0;
            if_id_valid_d    = 1'b0;
            // Depth is a power of two, so the pointer MSB alone means "full".
            if (!ld_ptr_q[AW]) begin
                mem_we      = 1'b1;
                ld_ptr_d    = ld_ptr_q + PTR_ONE;
                prog_len_d  = ld_ptr_q + PTR_ONE;
                imem_full_d = ((ld_ptr_q + PTR_ONE) == DEPTH_CNT);
            end else begin
                imem_full_d = 1'b1;
            end
        end else begin
            // Any low cycle re-arms the loader so the next burst starts at 0.
            ld_ptr_d = '0;
            if (branch_taken) begin
                pc_d          = branch_target & 32'hFFFF_FFFC;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (fetch_ok) begin
                fetch_fire       = 1'b1;
                if_id_instr_d    = mem_rdata;
                if_id_pc_plus4_d = pc_q + 32'd4;
                if_id_valid_d    = 1'b1;
                pc_d             = pc_q + 32'd4;
            end else begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q             <= pc_d;
        if_id_instr_q    <= if_id_instr_d;
        if_id_pc_plus4_q <= if_id_pc_plus4_d;
        if_id_valid_q    <= if_id_valid_d;
        ld_ptr_q         <= ld_ptr_d;
        prog_len_q       <= prog_len_d;
        imem_full_q      <= imem_full_d;
    end

    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign prog_len       = prog_len_q;
    assign imem_full      = imem_full_q;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (Reset) begin
            fetch_count_d = '0;
            stall_count_d = '0;
        end else begin
            if (fetch_fire && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
            if (stall && !branch_taken && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        fetch_count_q <= fetch_count_d;
        stall_count_q <= stall_count_d;
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter IMEM_DEPTH, default 64: instruction memory depth in 32-bit words (power of two, at least 4).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 LoadInstructions  input  1  load mode; while high, Instruction is written to the instruction memory each cycle.
REQ-005 Instruction  input  32  instruction word to load.
REQ-006 stall  input  1  hazard-unit request to hold PC and IF/ID.
REQ-007 branch_taken  input  1  redirect/flush request from a later stage.
REQ-008 branch_target  input  32  byte address for the redirect.
REQ-009 if_id_instr  output  32  registered instruction to decode.
REQ-010 if_id_pc_plus4  output  32  registered fetch PC+4.
REQ-011 if_id_valid  output  1  if_id_instr is a real fetched instruction.
REQ-012 prog_len  output  log2(IMEM_DEPTH)+1  number of words loaded.
REQ-013 imem_full  output  1  load pointer has reached IMEM_DEPTH.

Function
REQ-014 Load: the first LoadInstructions-high cycle after a low cycle or after Reset shall write address 0; each subsequent high cycle shall write the next address.
REQ-015 After each load write, prog_len shall equal the write pointer plus 1.
REQ-016 With the pointer at IMEM_DEPTH, writes shall be dropped, imem_full shall be 1, and prog_len shall hold at IMEM_DEPTH.
REQ-017 In load mode, PC shall be set to 0, if_id_instr to NOP (32'h0), and if_id_valid to 0.
REQ-018 Fetch (LoadInstructions low, Reset low): if PC[31:2] < prog_len, IF/ID shall capture imem[PC[31:2]] and PC+4 with valid 1, and PC shall advance by 4.
REQ-019 Fetch latency: one cycle; the memory read is combinational and IF/ID is registered.
REQ-020 End of program: if PC[31:2] >= prog_len, IF/ID shall capture NOP with valid 0 and PC shall hold.
REQ-021 Stall: PC and all IF/ID outputs shall hold.
REQ-022 Branch: PC shall load {branch_target[31:2],2'b00} and IF/ID shall become NOP with valid 0, costing one bubble.
REQ-023 Priority, highest first: Reset, LoadInstructions, branch_taken, stall, normal fetch.
REQ-024 A branch_target at or beyond prog_len shall halt fetch per REQ-020.
REQ-025 PC arithmetic shall be 32-bit modulo 2^32.

Reset
REQ-026 Reset shall set PC to 0, if_id_instr to 0, if_id_pc_plus4 to 0, if_id_valid to 0, and the load pointer to 0.
REQ-027 Reset shall not alter memory contents, prog_len, or imem_full, so a loaded program survives Reset.
REQ-028 prog_len shall power up at 0; Reset asserted during a load shall end the burst, keeping the words written so far.

Configuration
REQ-029 With IF_PERF_COUNT_EN defined, outputs fetch_count[31:0] and stall_count[31:0] shall exist.
REQ-030 fetch_count shall increment on each valid IF/ID capture; stall_count shall increment on each cycle with stall high and no branch.
REQ-031 Both counters shall saturate at 32'hFFFFFFFF and clear on Reset.
REQ-032 With IF_PERF_COUNT_EN undefined, neither the ports nor the logic shall exist, and all other behaviour shall be identical.

Structure
REQ-033 Shared package cpu_pkg shall hold NOP_INSTR (32'h0), DEFAULT_IMEM_DEPTH (64), and the instruction word width (32).
REQ-034 One sub-module, instr_mem, shall provide a single synchronous write port and an asynchronous read port; PC, load pointer, and IF/ID logic shall stay in instr_fetch_stage.

Verification
REQ-035 Load 11 words (first 32'h200101A7), drop LoadInstructions, pulse Reset for one cycle -> prog_len=11; first edge after Reset shall give if_id_instr=32'h200101A7, if_id_pc_plus4=4, valid 1.
REQ-036 After REQ-035, run 12 cycles -> words 0..10 appear in order, then NOP with valid 0, PC held at 44.
REQ-037 Stall high for 3 cycles at PC=8 -> IF/ID held at word 1 (pc_plus4=8) for 3 cycles; word 2 follows stall release.
REQ-038 branch_taken with branch_target=32'h0000000E and stall also high -> one NOP bubble with valid 0, then word 3 with pc_plus4=16.
REQ-039 IMEM_DEPTH=4, load 6 words -> imem_full=1, prog_len=4, words 4 and 5 dropped, memory holds words 0..3.
REQ-040 Reset asserted after 3 load words, then a new load burst -> prog_len=3 after Reset; the new burst writes from address 0.
